bcd_sevenseg_scan: RTL and testbench
====================================

// Module: bcd_sevenseg_scan
// PURPOSE
//  Time-multiplexed seven-segment driver; downstream consumer of the calculator's binary-to-BCD digit outputs.
//  Latches a packed BCD word on a load strobe and applies it only at frame boundaries (tear-free).
//  Scans one digit per refresh period: invalid codes show '-', optional leading-zero blanking, per-digit decimal point.
// PARAMETERS
//  NUM_DIGITS   4       number of digits/anodes (>=2)
//  REFRESH_DIV  100000  clk cycles each digit is lit (>=2; 4 in sim)
//  ACTIVE_LOW   1       1: seg/dp/an active-low (board); 0: active-high
// PORTS
//  clk       in   1             system clock
//  rst_n     in   1             asynchronous active-low reset
//  load      in   1             1-cycle strobe: capture bcd_in/dp_in/blank_lz into shadow
//  bcd_in    in   4*NUM_DIGITS  packed BCD; digit k = bcd_in[4k+3:4k]; k=0 is least significant
//  dp_in     in   NUM_DIGITS    decimal point per digit (1 = lit)
//  blank_lz  in   1             1 = blank leading zeros
//  seg       out  7             {g,f,e,d,c,b,a}, registered
//  dp        out  1             decimal point, registered
//  an        out  NUM_DIGITS    one-hot anode enable, registered
//  applied   out  1             1-cycle pulse when shadow copied to active
// BEHAVIOUR
//  Polarity: all encodings below are active-high; when ACTIVE_LOW=1, seg/dp/an are inverted at the output registers.
//  Reset (async, rst_n=0):
//   - refresh counter = 0, digit index = 0.
//   - shadow/active regs = 0; pending = 0; applied = 0.
//   - an/seg/dp all inactive (all-ones when ACTIVE_LOW=1).
//   - Reset mid-frame aborts the scan; pending loads are discarded.
//  Refresh counter: counts 0..REFRESH_DIV-1.
//   - At terminal count: counter -> 0; index advances, NUM_DIGITS-1 wraps to 0.
//   - Frame boundary = the edge at which index wraps to 0.
//  Load: at the load edge, shadow <= {bcd_in, dp_in, blank_lz} and pending <= 1.
//   - Load while pending overwrites shadow (last wins).
//  Apply: at a frame-boundary edge with pending=1 (value before the edge):
//   - active <= shadow, pending <= 0, applied = 1 for exactly one cycle.
//   - Load on the same edge: boundary applies the old shadow; new data captured, pending stays 1 -> applied next frame.
//   - Same-edge load with pending=0: nothing applied; pending set.
//  Output regs: each cycle an/seg/dp <= decode(active, index); latency 1 cycle after an index change.
//   - an = one-hot at bit index.
//  Decode: 0..9 standard; a-f lit for 0 = 7'h3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
//   - Codes 10..15 -> '-' (7'h40).
//  Leading-zero blanking (active blank_lz=1): digit k is blank (seg=0, an still driven) iff k>0 and all digits k..NUM_DIGITS-1 equal 0.
//   - Digit 0 is never blanked; an invalid code stops blanking.
//   - dp of a blanked digit still follows dp_in.
//  Scan is free-running; load never stalls or restarts it.
// TESTING (NUM_DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=0)
//  1 Reset: hold rst_n=0 -> an=0, seg=0, dp=0, applied=0; release -> an=0001 next cycle, each digit lit 4 cycles, order 0001,0010,0100,1000,0001.
//  2 Load 0x1234 mid-frame -> display unchanged until boundary; applied pulses at wrap; then digit0 seg=66, d1=4F, d2=5B, d3=06.
//  3 blank_lz=1, bcd_in=0x0070 -> d0=3F, d1=07, d2=00, d3=00; bcd_in=0x0000 -> only d0=3F lit.
//  4 bcd_in=0x0A0F -> d0 and d2 show 40; blank_lz=1 keeps d3 blank (zero above invalid d2), d1=3F shown.
//  5 Two loads (0x1111 then 0x2222) within one frame -> single applied pulse, 0x2222 displayed; load coincident with wrap -> applied one frame later.
//  6 Assert rst_n=0 with pending=1 mid-frame -> outputs inactive immediately; after release active=0, no applied pulse ever occurs.

Source files
------------

// File: rtl/bcd_sevenseg_scan.sv
// Time-multiplexed seven-segment driver: a packed BCD word is captured into a shadow
// register and copied to the displayed set only at frame boundaries, so a frame never tears.
module bcd_sevenseg_scan #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   bcd_in,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic                      blank_lz,
  output logic [6:0]                seg,
  output logic                      dp,
  output logic [NUM_DIGITS-1:0]     an,
  output logic                      applied
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [6:0]    SEG_OFF  = {7{ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{ACTIVE_LOW}};

  logic [CW-1:0]             cnt_q, cnt_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0]   sh_bcd_q, sh_bcd_d, act_bcd_q, act_bcd_d;
  logic [NUM_DIGITS-1:0]     sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
  logic                      sh_blz_q, sh_blz_d, act_blz_q, act_blz_d;
  logic                      pending_q, pending_d, applied_q, applied_d;
  logic [6:0]                seg_q, seg_d;
  logic                      dp_q, dp_d;
  logic [NUM_DIGITS-1:0]     an_q, an_d;
  logic                      terminal, wrap;

  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    case (code)
      4'd0:    seg_decode = 7'h3F;
      4'd1:    seg_decode = 7'h06;
      4'd2:    seg_decode = 7'h5B;
      4'd3:    seg_decode = 7'h4F;
      4'd4:    seg_decode = 7'h66;
      4'd5:    seg_decode = 7'h6D;
      4'd6:    seg_decode = 7'h7D;
      4'd7:    seg_decode = 7'h07;
      4'd8:    seg_decode = 7'h7F;
      4'd9:    seg_decode = 7'h6F;
      default: seg_decode = 7'h40;
    endcase
  endfunction

  // zero_from[k]: digits k..NUM_DIGITS-1 of the active word are all zero.
  // An invalid code is non-zero, so it naturally stops blanking below it.
  logic [NUM_DIGITS-1:1] zero_from;
  logic [6:0]            digit_seg [NUM_DIGITS];

  genvar gi;
  generate
    for (gi = 1; gi < NUM_DIGITS; gi++) begin : g_zero
      if (gi == NUM_DIGITS - 1) begin : g_top
        assign zero_from[gi] = (act_bcd_q[4*gi +: 4] == 4'd0);
      end else begin : g_mid
        assign zero_from[gi] = (act_bcd_q[4*gi +: 4] == 4'd0) & zero_from[gi+1];
      end
    end
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      if (gi == 0) begin : g_lsd
        assign digit_seg[gi] = seg_decode(act_bcd_q[3:0]);
      end else begin : g_upper
        assign digit_seg[gi] = (act_blz_q && zero_from[gi]) ? 7'h00
                                                            : seg_decode(act_bcd_q[4*gi +: 4]);
      end
    end
  endgenerate

  assign terminal = (cnt_q == CNT_LAST);
  assign wrap     = terminal && (idx_q == IDX_LAST);

  always_comb begin
    cnt_d     = terminal ? '0 : cnt_q + 1'b1;
    idx_d     = idx_q;
    if (terminal) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    sh_bcd_d  = sh_bcd_q;
    sh_dp_d   = sh_dp_q;
    sh_blz_d  = sh_blz_q;
    act_bcd_d = act_bcd_q;
    act_dp_d  = act_dp_q;
    act_blz_d = act_blz_q;
    pending_d = pending_q;
    applied_d = 1'b0;
    // Apply uses the pre-edge shadow; a coincident load then re-arms pending.
    if (wrap && pending_q) begin
      act_bcd_d = sh_bcd_q;
      act_dp_d  = sh_dp_q;
      act_blz_d = sh_blz_q;
      pending_d = 1'b0;
      applied_d = 1'b1;
    end
    if (load) begin
      sh_bcd_d  = bcd_in;
      sh_dp_d   = dp_in;
      sh_blz_d  = blank_lz;
      pending_d = 1'b1;
    end
    seg_d = digit_seg[idx_q] ^ SEG_OFF;
    dp_d  = act_dp_q[idx_q] ^ ACTIVE_LOW;
    an_d  = (NUM_DIGITS'(1) << idx_q) ^ AN_OFF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      sh_bcd_q  <= '0;
      sh_dp_q   <= '0;
      sh_blz_q  <= 1'b0;
      act_bcd_q <= '0;
      act_dp_q  <= '0;
      act_blz_q <= 1'b0;
      pending_q <= 1'b0;
      applied_q <= 1'b0;
      seg_q     <= SEG_OFF;
      dp_q      <= ACTIVE_LOW;
      an_q      <= AN_OFF;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      sh_bcd_q  <= sh_bcd_d;
      sh_dp_q   <= sh_dp_d;
      sh_blz_q  <= sh_blz_d;
      act_bcd_q <= act_bcd_d;
      act_dp_q  <= act_dp_d;
      act_blz_q <= act_blz_d;
      pending_q <= pending_d;
      applied_q <= applied_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      an_q      <= an_d;
    end
  end

  assign seg     = seg_q;
  assign dp      = dp_q;
  assign an      = an_q;
  assign applied = applied_q;

endmodule

// File: tb/tb_bcd_sevenseg_scan.sv
// Directed bench for bcd_sevenseg_scan (4 digits, 4-cycle refresh, active-high outputs).
module tb_bcd_sevenseg_scan;
  localparam int ND = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load = 1'b0;
  logic [15:0]   bcd_in = '0;
  logic [3:0]    dp_in = '0;
  logic          blank_lz = 1'b0;
  logic [6:0]    seg;
  logic          dp;
  logic [3:0]    an;
  logic          applied;

  bcd_sevenseg_scan #(.NUM_DIGITS(ND), .REFRESH_DIV(4), .ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .bcd_in(bcd_in), .dp_in(dp_in),
    .blank_lz(blank_lz), .seg(seg), .dp(dp), .an(an), .applied(applied)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bcd;
    logic [3:0]  dpv;
    logic        blz;
    logic [27:0] eseg;   // {d3,d2,d1,d0}
    logic [3:0]  edp;
  } vec_t;

  vec_t        tbl [7];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [6:0]  got_seg [ND];
  logic        got_dp [ND];
  int          got_app;
  bit          order_bad;
  logic [27:0] prev_seg;
  logic [3:0]  prev_dp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int an_index(input logic [3:0] a);
    for (int i = 0; i < ND; i++) if (a[i]) return i;
    return 0;
  endfunction

  // Called right after the sample where applied pulsed (or right after reset release):
  // the next 16 samples show digits 0..3 for four cycles each.
  task automatic capture_frame();
    order_bad = 1'b0;
    got_app = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (an !== (4'b0001 << (c / 4))) order_bad = 1'b1;
      got_seg[c / 4] = seg;
      got_dp[c / 4]  = dp;
      if (applied) got_app++;
    end
  endtask

  task automatic check_frame(input string tag, input logic [27:0] eseg, input logic [3:0] edp,
                             input int eapp);
    check({tag, "_order"}, 32'(order_bad), 32'd0);
    for (int k = 0; k < ND; k++) begin
      check($sformatf("%s_seg%0d", tag, k), 32'(got_seg[k]), 32'(eseg[7*k +: 7]));
      check($sformatf("%s_dp%0d", tag, k), 32'(got_dp[k]), 32'(edp[k]));
    end
    check({tag, "_applied_cnt"}, 32'(got_app), 32'(eapp));
  endtask

  task automatic do_load(input logic [15:0] b, input logic [3:0] d, input logic z);
    bcd_in = b; dp_in = d; blank_lz = z; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Display must keep showing the previous word until the applied pulse.
  task automatic wait_applied_hold(input string tag);
    bit found = 1'b0;
    int k;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      k = an_index(an);
      check({tag, "_hold"}, 32'(seg), 32'(prev_seg[7*k +: 7]));
      if (applied) begin found = 1'b1; break; end
    end
    check({tag, "_applied_seen"}, 32'(found), 32'd1);
  endtask

  task automatic wait_an(input logic [3:0] target);
    bit found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (an == target) begin found = 1'b1; break; end
    end
    check("align_an", 32'(found), 32'd1);
  endtask

  initial begin
    int lat;
    tbl[0] = '{16'h1234, 4'b0000, 1'b0, {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b0000};
    tbl[1] = '{16'h0070, 4'b0000, 1'b1, {7'h00, 7'h00, 7'h07, 7'h3F}, 4'b0000};
    tbl[2] = '{16'h0000, 4'b0110, 1'b1, {7'h00, 7'h00, 7'h00, 7'h3F}, 4'b0110};
    tbl[3] = '{16'h0A0F, 4'b0000, 1'b1, {7'h00, 7'h40, 7'h3F, 7'h40}, 4'b0000};
    tbl[4] = '{16'h9876, 4'b1001, 1'b0, {7'h6F, 7'h7F, 7'h07, 7'h7D}, 4'b1001};
    tbl[5] = '{16'h0005, 4'b0000, 1'b0, {7'h3F, 7'h3F, 7'h3F, 7'h6D}, 4'b0000};
    tbl[6] = '{16'hB00C, 4'b0000, 1'b1, {7'h40, 7'h3F, 7'h3F, 7'h40}, 4'b0000};

    // Reset state and scan order
    repeat (3) @(negedge clk);
    check("rst_an", 32'(an), 32'd0);
    check("rst_seg", 32'(seg), 32'd0);
    check("rst_dp", 32'(dp), 32'd0);
    check("rst_applied", 32'(applied), 32'd0);
    rst_n = 1'b1;
    capture_frame();
    check_frame("post_reset", {4{7'h3F}}, 4'b0000, 0);
    @(negedge clk);
    check("scan_wrap_an", 32'(an), 32'b0001);
    prev_seg = {4{7'h3F}};
    prev_dp  = 4'b0000;

    // Table: mid-frame load, hold until boundary, then check a whole frame
    for (int v = 0; v < 7; v++) begin
      do_load(tbl[v].bcd, tbl[v].dpv, tbl[v].blz);
      wait_applied_hold($sformatf("vec%0d", v));
      capture_frame();
      check_frame($sformatf("vec%0d", v), tbl[v].eseg, tbl[v].edp, 0);
      prev_seg = tbl[v].eseg;
      prev_dp  = tbl[v].edp;
    end

    // Two loads in one frame: last wins, single applied pulse
    do_load(16'h1111, 4'b0000, 1'b0);
    do_load(16'h2222, 4'b0000, 1'b0);
    wait_applied_hold("double");
    capture_frame();
    check_frame("double", {4{7'h5B}}, 4'b0000, 0);

    // Load coincident with wrap while nothing pending: applied one frame later
    wait_an(4'b1000);
    repeat (2) @(negedge clk);
    do_load(16'h7777, 4'b0000, 1'b0);
    check("coinc_no_apply", 32'(applied), 32'd0);
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (applied) begin lat = c; break; end
    end
    check("coinc_latency", 32'(lat), 32'd16);

    // Coincident load while pending: old shadow applied now, new one next frame
    do_load(16'h3333, 4'b0000, 1'b0);
    wait_an(4'b1000);
    repeat (2) @(negedge clk);
    do_load(16'h4444, 4'b0000, 1'b0);
    check("coinc_pend_apply", 32'(applied), 32'd1);
    capture_frame();
    check_frame("coinc_old", {4{7'h4F}}, 4'b0000, 1);
    capture_frame();
    check_frame("coinc_new", {4{7'h66}}, 4'b0000, 0);

    // Reset mid-frame with a load pending
    do_load(16'h5555, 4'b1111, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_an", 32'(an), 32'd0);
    check("midrst_seg", 32'(seg), 32'd0);
    check("midrst_dp", 32'(dp), 32'd0);
    check("midrst_applied", 32'(applied), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    capture_frame();
    check_frame("midrst_f1", {4{7'h3F}}, 4'b0000, 0);
    capture_frame();
    check_frame("midrst_f2", {4{7'h3F}}, 4'b0000, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
